scan_chain_loader: RTL

//  Host-side master for the processor scan chain (scan_enable/scan_in/scan_out).

---
 rtl/scan_chain_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/scan_chain_loader.sv
// Scan-chain master: streams host bytes into the chain LSB-first and returns captured tail bytes; CRC-8 of captured bits when SCAN_CHAIN_LOADER_CRC_EN is defined.
// Latency: one chain bit per cycle while a byte is buffered; done pulses the cycle after the final out_data is taken.
// Backpressure: shifting stalls (scan_enable low) while the input buffer is empty or out_data is still unconsumed.
module scan_chain_loader #(
    parameter int CHAIN_LEN = 152
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       run_after,
    output logic       busy,
    output logic       done,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       scan_enable,
    output logic       scan_in,
    input  logic       scan_out,
    output logic       processor_enable,
    output logic [7:0] crc
);

    localparam int NBYTES = (CHAIN_LEN + 7) / 8;
    localparam int BW     = $clog2(CHAIN_LEN + 1);
    localparam int YW     = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} state_t;

    state_t          state_q;
    logic            run_q;
    logic            pen_q;
    logic            busy_q;
    logic            done_q;
    logic [7:0]      buf_q;
    logic            buf_vld_q;
    logic [YW-1:0]   nbytes_q;
    logic [BW-1:0]   nbits_q;
    logic [7:0]      coll_q;
    logic [7:0]      coll_d;
    logic [7:0]      odat_q;
    logic            ovld_q;

    logic [2:0]      bit_idx;
    logic            shift_en;
    logic            last_bit;
    logic            accept;

    // Byte boundaries coincide with multiples of 8 in the global bit count.
    assign bit_idx  = nbits_q[2:0];
    assign last_bit = (nbits_q == BW'(CHAIN_LEN - 1));
    assign shift_en = (state_q == SHIFT) && buf_vld_q && !ovld_q;
    assign in_ready = (state_q == SHIFT) && !buf_vld_q && (nbytes_q < YW'(NBYTES));
    assign accept   = in_valid && in_ready;

    assign scan_enable      = shift_en;
    assign scan_in          = shift_en & buf_q[bit_idx];
    assign busy             = busy_q;
    assign done             = done_q;
    assign out_data         = odat_q;
    assign out_valid        = ovld_q;
    assign processor_enable = pen_q;

    always_comb begin
        coll_d          = coll_q;
        coll_d[bit_idx] = scan_out;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            run_q     <= 1'b0;
            pen_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            buf_q     <= 8'h00;
            buf_vld_q <= 1'b0;
            nbytes_q  <= '0;
            nbits_q   <= '0;
            coll_q    <= 8'h00;
            odat_q    <= 8'h00;
            ovld_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ovld_q && out_ready) begin
                ovld_q <= 1'b0;
            end
            if (accept) begin
                buf_q     <= in_data;
                buf_vld_q <= 1'b1;
                nbytes_q  <= nbytes_q + YW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= SHIFT;
                        run_q    <= run_after;
                        pen_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        nbytes_q <= '0;
                        nbits_q  <= '0;
                        coll_q   <= 8'h00;
                    end else if (done_q) begin
                        pen_q <= run_q;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        nbits_q <= nbits_q + BW'(1);
                        if (bit_idx == 3'd7 || last_bit) begin
                            // Collector is cleared per byte, so a short last byte has zero high bits.
                            buf_vld_q <= 1'b0;
                            odat_q    <= coll_d;
                            ovld_q    <= 1'b1;
                            coll_q    <= 8'h00;
                        end else begin
                            coll_q <= coll_d;
                        end
                        if (last_bit) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (!ovld_q || out_ready) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SCAN_CHAIN_LOADER_CRC_EN
    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic       crc_fb;

    always_comb begin
        crc_fb = crc_q[7] ^ scan_out;
        crc_d  = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            crc_q <= 8'h00;
        end else if (state_q == IDLE && start) begin
            crc_q <= 8'h00;
        end else if (shift_en) begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;
`else
    assign crc = 8'h00;
`endif

endmodule
